// File: rtl/ps_pkg.sv
// Shared definitions for the program sequencer and its users (decoder, bench).
//   ADDR_W_DEFAULT     : default program-address width
//   RESET_ADDR_DEFAULT : default address fetched after reset
//   ps_action_e        : one-hot-free encoding of the single action taken per cycle
//   select_action()    : priority encoder from decoder strobes to ps_action_e
package ps_pkg;

    localparam int ADDR_W_DEFAULT     = 8;
    localparam int RESET_ADDR_DEFAULT = 0;

    typedef enum logic [2:0] {
        PS_RESET,
        PS_HOLD,
        PS_JMP,
        PS_JNZ,
        PS_CALL,
        PS_RET,
        PS_INC
    } ps_action_e;

    // Exactly one action wins per cycle; everything below the winner is ignored.
    // A conditional jump whose zero flag is set is simply not a request.
    function automatic ps_action_e select_action(
        input logic sync_reset,
        input logic hold,
        input logic jmp,
        input logic jmp_nz,
        input logic dont_jmp,
        input logic call,
        input logic ret
    );
        if (sync_reset)               return PS_RESET;
        else if (hold)                return PS_HOLD;
        else if (jmp)                 return PS_JMP;
        else if (jmp_nz && !dont_jmp) return PS_JNZ;
        else if (call)                return PS_CALL;
        else if (ret)                 return PS_RET;
        else                          return PS_INC;
    endfunction

endpackage

// File: rtl/ps_return_stack.sv
// Hardware return-address stack (LIFO) for the program sequencer.
//   clk, reset_n : clock, asynchronous active-low reset (clears level only)
//   clear        : synchronous clear of the level
//   push, pop    : push push_data / pop top_data; ignored when full / empty
//   push_data    : address to store
//   top_data     : entry at level-1 (valid only when !empty)
//   level        : number of valid entries, 0..DEPTH
//   full, empty  : level == DEPTH / level == 0
module ps_return_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int SP_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic [SP_W-1:0]  level,
    output logic             full,
    output logic             empty
);

    // Entry index width; the array is rounded up to a power of two so the
    // truncated level always addresses a real entry.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MEM_N = 1 << IDX_W;

    logic [WIDTH-1:0] mem_q [MEM_N];
    logic [SP_W-1:0]  level_q, level_d;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             do_push, do_pop;

    assign full    = (level_q == SP_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !do_push;
    assign wr_idx  = IDX_W'(level_q);
    assign rd_idx  = IDX_W'(level_q - SP_W'(1));

    assign top_data = mem_q[rd_idx];
    assign level    = level_q;

    always_comb begin
        // NOTE: assign a default first so every path drives level_d; a missing
        // branch in always_comb would otherwise infer a latch.
        level_d = level_q;
        if (clear)        level_d = '0;
        else if (do_push) level_d = level_q + SP_W'(1);
        else if (do_pop)  level_d = level_q - SP_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) level_q <= '0;
        else          level_q <= level_d;
    end

    // NOTE: the entry array has no reset; contents are meaningless while
    // level is 0, and leaving it unreset keeps it plain register/RAM storage.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_idx] <= push_data;
    end

endmodule

// File: rtl/program_sequencer_stack.sv
// Program sequencer with return-address stack.
// Computes the next program-memory fetch address each cycle and holds the PC.
//   clk, reset_n  : clock, asynchronous active-low reset
//   sync_reset    : synchronous reset strobe (highest priority)
//   hold          : re-fetch current pc, stack untouched
//   jmp, jmp_nz   : unconditional / conditional jump to jmp_addr
//   dont_jmp      : ALU zero flag, suppresses jmp_nz
//   call, ret     : subroutine call (push pc+1) / return (pop)
//   jmp_addr      : jump/call target
//   pm_address    : combinational next fetch address
//   pc, from_PS   : registered address of instruction in flight
//   stack_level   : valid return-stack entries
//   stack_err     : sticky overflow/underflow flag
module program_sequencer_stack
    import ps_pkg::*;
#(
    parameter int                ADDR_W      = ADDR_W_DEFAULT,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = ADDR_W'(RESET_ADDR_DEFAULT),
    localparam int               SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sync_reset,
    input  logic              hold,
    input  logic              jmp,
    input  logic              jmp_nz,
    input  logic              dont_jmp,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic [ADDR_W-1:0] pm_address,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] from_PS,
    output logic [SP_W-1:0]   stack_level,
    output logic              stack_err
);

    ps_action_e        action;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, top_data;
    logic              stack_err_q, stack_err_d;
    logic              push, pop, clear, err_set, full, empty;

    assign action = select_action(sync_reset, hold, jmp, jmp_nz, dont_jmp, call, ret);
    assign pc_inc = pc_q + ADDR_W'(1);   // wraps modulo 2**ADDR_W

    always_comb begin
        pc_d    = pc_inc;
        push    = 1'b0;
        pop     = 1'b0;
        clear   = 1'b0;
        err_set = 1'b0;
        unique case (action)
            PS_RESET: begin
                pc_d  = RESET_ADDR;
                clear = 1'b1;
            end
            PS_HOLD:        pc_d = pc_q;
            PS_JMP, PS_JNZ: pc_d = jmp_addr;
            PS_CALL: begin
                // Overflow: the call is dropped and execution falls through.
                if (!full) begin
                    pc_d = jmp_addr;
                    push = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
            end
            PS_RET: begin
                // Underflow: nothing to return to, fall through.
                if (!empty) begin
                    pc_d = top_data;
                    pop  = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
            end
            default: pc_d = pc_inc;
        endcase
    end

    assign stack_err_d = clear ? 1'b0 : (stack_err_q | err_set);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q        <= RESET_ADDR;
            stack_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            stack_err_q <= stack_err_d;
        end
    end

    ps_return_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (top_data),
        .level     (stack_level),
        .full      (full),
        .empty     (empty)
    );

    assign pm_address = pc_d;
    assign pc         = pc_q;
    assign from_PS    = pc_q;
    assign stack_err  = stack_err_q;

endmodule

// File: tb/tb_program_sequencer_stack.sv
module tb_program_sequencer_stack;

    localparam int         ADDR_W = 8;
    localparam int         DEPTH  = 4;
    localparam logic [7:0] RST_A  = 8'h00;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sync_reset, hold, jmp, jmp_nz, dont_jmp, call, ret;
    logic [7:0] jmp_addr;
    logic [7:0] pm_address, pc, from_PS;
    logic [2:0] stack_level;
    logic       stack_err;

    int checks = 0;
    int errors = 0;

    // Reference model: pc value, a queue as the return stack, sticky error bit.
    logic [7:0] m_pc;
    logic [7:0] m_stack[$];
    bit         m_err;

    program_sequencer_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (DEPTH),
        .RESET_ADDR  (RST_A)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sync_reset  (sync_reset),
        .hold        (hold),
        .jmp         (jmp),
        .jmp_nz      (jmp_nz),
        .dont_jmp    (dont_jmp),
        .call        (call),
        .ret         (ret),
        .jmp_addr    (jmp_addr),
        .pm_address  (pm_address),
        .pc          (pc),
        .from_PS     (from_PS),
        .stack_level (stack_level),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, " pc"}, 32'(pc), 32'(m_pc));
        check({tag, " from_PS"}, 32'(from_PS), 32'(m_pc));
        check({tag, " level"}, 32'(stack_level), 32'(m_stack.size()));
        check({tag, " err"}, 32'(stack_err), 32'(m_err));
    endtask

    // One cycle: drive strobes, predict and check the fetch address, clock,
    // then check the registered state.
    task automatic step(input string tag, input logic sr, input logic h, input logic j,
                        input logic jn, input logic dz, input logic c, input logic r,
                        input logic [7:0] ja);
        logic [7:0] exp_pm;
        sync_reset = sr; hold = h; jmp = j; jmp_nz = jn; dont_jmp = dz;
        call = c; ret = r; jmp_addr = ja;
        #1;
        if (sr) begin
            exp_pm = RST_A;
            m_stack.delete();
            m_err = 1'b0;
        end else if (h) begin
            exp_pm = m_pc;
        end else if (j || (jn && !dz)) begin
            exp_pm = ja;
        end else if (c) begin
            if (m_stack.size() < DEPTH) begin
                exp_pm = ja;
                m_stack.push_back(m_pc + 8'd1);
            end else begin
                exp_pm = m_pc + 8'd1;
                m_err  = 1'b1;
            end
        end else if (r) begin
            if (m_stack.size() > 0) begin
                exp_pm = m_stack.pop_back();
            end else begin
                exp_pm = m_pc + 8'd1;
                m_err  = 1'b1;
            end
        end else begin
            exp_pm = m_pc + 8'd1;
        end
        check({tag, " pm_address"}, 32'(pm_address), 32'(exp_pm));
        @(posedge clk);
        #1;
        m_pc = exp_pm;
        check_state(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        // 1: reset, then free-running increment
        reset_n = 1'b0;
        sync_reset = 0; hold = 0; jmp = 0; jmp_nz = 0; dont_jmp = 0;
        call = 0; ret = 0; jmp_addr = 8'h00;
        m_pc = RST_A; m_err = 1'b0; m_stack.delete();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) idle("inc");

        // 2: call then return
        step("jmp10", 0, 0, 1, 0, 0, 0, 0, 8'h10);
        step("call40", 0, 0, 0, 0, 0, 1, 0, 8'h40);
        step("ret11", 0, 0, 0, 0, 0, 0, 1, 8'h00);
        check("ret11 value", 32'(pc), 32'h11);

        // 3: overflow on the 5th nested call, underflow on the 5th return
        for (int i = 0; i < 5; i++) step("nest_call", 0, 0, 0, 0, 0, 1, 0, 8'(8'h20 + 16 * i));
        for (int i = 0; i < 5; i++) step("nest_ret", 0, 0, 0, 0, 0, 0, 1, 8'h00);
        check("underflow err", 32'(stack_err), 32'h1);

        // 4: conditional jump, jmp beats call, call beats ret
        step("sreset4", 1, 0, 0, 0, 0, 0, 0, 8'h00);
        step("jnz_zero", 0, 0, 0, 1, 1, 0, 0, 8'h80);
        step("jnz_take", 0, 0, 0, 1, 0, 0, 0, 8'h80);
        step("jmp_call", 0, 0, 1, 0, 0, 1, 0, 8'h90);
        step("call_ret", 0, 0, 0, 0, 0, 1, 1, 8'hA0);

        // 5: hold with call pending, pc wrap
        for (int i = 0; i < 3; i++) step("hold", 0, 1, 0, 0, 0, 1, 0, 8'h55);
        step("jmpFF", 0, 0, 1, 0, 0, 0, 0, 8'hFF);
        idle("wrap");
        step("callFF", 0, 0, 1, 0, 0, 0, 0, 8'hFF);
        step("call_wrap", 0, 0, 0, 0, 0, 1, 0, 8'h33);
        step("ret_wrap", 0, 0, 0, 0, 0, 0, 1, 8'h00);

        // 6: sync reset clears level/err; async reset mid-call
        step("sreset6a", 1, 0, 0, 0, 0, 0, 0, 8'h00);
        step("uflow", 0, 0, 0, 0, 0, 0, 1, 8'h00);
        step("lvl1", 0, 0, 0, 0, 0, 1, 0, 8'h40);
        step("lvl2", 0, 0, 0, 0, 0, 1, 0, 8'h50);
        step("sreset6b", 1, 0, 0, 0, 0, 1, 1, 8'h00);
        step("pre_async", 0, 0, 0, 0, 0, 1, 0, 8'h60);
        call = 1'b1; jmp_addr = 8'h70;
        #2;
        reset_n = 1'b0;
        #1;
        m_pc = RST_A; m_stack.delete(); m_err = 1'b0;
        check_state("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        call = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0),
                 1'($urandom),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0),
                 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
